// File: rtl/jk_drv_pkg.sv
// -----------------------------------------------------------------------------
// jk_drv_pkg
// Shared definitions for the JK bank write-side controller.
//   - Command opcodes carried on cmd_op.
//   - FSM state encoding used by jk_bank_driver (binary).
// -----------------------------------------------------------------------------
package jk_drv_pkg;

    // Command opcodes (cmd_op)
    localparam logic [1:0] OP_LOAD = 2'b00;   // target = cmd_data
    localparam logic [1:0] OP_INC  = 2'b01;   // target = q_fb + 1 (wraps)
    localparam logic [1:0] OP_CLR  = 2'b10;   // target = 0
    localparam logic [1:0] OP_TOG  = 2'b11;   // target = ~q_fb

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage : jk_drv_pkg

// File: rtl/jk_excite.sv
// -----------------------------------------------------------------------------
// jk_excite
// Combinational JK excitation for a W-bit bank: given the present state q and
// the wanted next state t, produce the J/K pair that moves each bit there.
//   q == t       -> J=0 K=0 (hold)
//   q=0, t=1     -> J=1 K=0 (set)
//   q=1, t=0     -> J=0 K=1 (reset)
// J=K=1 (toggle) is never produced, so the bank result does not depend on how
// many edges the pair stays applied.
// Ports:
//   i_q  in  W  present bank state
//   i_t  in  W  target state
//   o_j  out W  J excitation
//   o_k  out W  K excitation
// -----------------------------------------------------------------------------
module jk_excite #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_q,
    input  logic [W-1:0] i_t,
    output logic [W-1:0] o_j,
    output logic [W-1:0] o_k
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            assign o_j[gi] = ~i_q[gi] &  i_t[gi];
            assign o_k[gi] =  i_q[gi] & ~i_t[gi];
        end
    endgenerate

endmodule : jk_excite

// File: rtl/jk_bank_driver.sv
// -----------------------------------------------------------------------------
// jk_bank_driver
// Write-side controller for a bank of W external JK flip-flops. A command is
// accepted over a valid/ready handshake, a target word is latched, and J/K are
// driven for exactly one clock. The fed-back bank state is then checked; on a
// mismatch the bank is re-driven up to MAX_RETRY times before a sticky error.
// Ports:
//   CLK        in   1  system clock
//   RST        in   1  asynchronous active-high reset
//   cmd_valid  in   1  command present
//   cmd_op     in   2  00 LOAD, 01 INC, 10 CLR, 11 TOG
//   cmd_data   in   W  target word (LOAD only)
//   cmd_ready  out  1  high only in IDLE
//   q_fb       in   W  current Q of the JK bank
//   J          out  W  J inputs of the bank (registered)
//   K          out  W  K inputs of the bank (registered)
//   busy       out  1  high in DRIVE/CHECK/DONE
//   done       out  1  one-cycle pulse when the bank reached the target
//   err        out  1  sticky: target not reached after all retries
//   err_clr    in   1  clears err and returns ERR -> IDLE
// -----------------------------------------------------------------------------
module jk_bank_driver
    import jk_drv_pkg::*;
#(
    parameter int W         = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         cmd_valid,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic         cmd_ready,
    input  logic [W-1:0] q_fb,
    output logic [W-1:0] J,
    output logic [W-1:0] K,
    output logic         busy,
    output logic         done,
    output logic         err,
    input  logic         err_clr
);

    // Counter wide enough for 0..MAX_RETRY, at least one bit.
    localparam int            RW          = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    state_t        r_state;
    logic [W-1:0]  r_tgt;
    logic [W-1:0]  r_j;
    logic [W-1:0]  r_k;
    logic [RW-1:0] r_retry;
    logic          r_done;
    logic          r_err;

    logic [W-1:0]  w_tgt_new;
    logic [W-1:0]  w_exc_t;
    logic [W-1:0]  w_j;
    logic [W-1:0]  w_k;

    // Target computed from the command and the bank state of the accept cycle.
    always_comb begin
        w_tgt_new = cmd_data;
        case (cmd_op)
            OP_LOAD: w_tgt_new = cmd_data;
            OP_INC:  w_tgt_new = q_fb + W'(1);
            OP_CLR:  w_tgt_new = '0;
            OP_TOG:  w_tgt_new = ~q_fb;
            default: w_tgt_new = cmd_data;
        endcase
    end

    // J/K are registered on the edge that enters DRIVE, so the excitation is
    // computed one cycle ahead: from the incoming target when accepting in
    // IDLE, from the latched target when re-driving out of CHECK.
    assign w_exc_t = (r_state == ST_IDLE) ? w_tgt_new : r_tgt;

    jk_excite #(
        .W (W)
    ) u_excite (
        .i_q (q_fb),
        .i_t (w_exc_t),
        .o_j (w_j),
        .o_k (w_k)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_tgt   <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_retry <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // J/K and done are single-cycle: cleared unless a state sets them.
            r_j    <= '0;
            r_k    <= '0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_tgt   <= w_tgt_new;
                        r_retry <= '0;
                        r_j     <= w_j;
                        r_k     <= w_k;
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (q_fb == r_tgt) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (r_retry < RETRY_LIMIT) begin
                        r_retry <= r_retry + RW'(1);
                        r_j     <= w_j;
                        r_k     <= w_k;
                        r_state <= ST_DRIVE;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= ST_ERR;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                ST_ERR: begin
                    if (err_clr) begin
                        r_err   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign J         = r_j;
    assign K         = r_k;
    assign done      = r_done;
    assign err       = r_err;
    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE) && (r_state != ST_ERR);

endmodule : jk_bank_driver

// File: tb/tb_jk_bank_driver.sv
// -----------------------------------------------------------------------------
// tb_jk_bank_driver
// Bench for jk_bank_driver (W=4, MAX_RETRY=2). A behavioural JK bank closes the
// loop (Q reset to 0, can be made stuck). Each command is predicted from the
// opcode rules and a JK truth table, then followed cycle by cycle.
// -----------------------------------------------------------------------------
module tb_jk_bank_driver;

    localparam int         W     = 4;
    localparam int         MAXR  = 2;
    localparam logic [1:0] C_LOAD = 2'b00;
    localparam logic [1:0] C_INC  = 2'b01;
    localparam logic [1:0] C_CLR  = 2'b10;
    localparam logic [1:0] C_TOG  = 2'b11;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_data = '0;
    logic         cmd_ready;
    logic [W-1:0] J;
    logic [W-1:0] K;
    logic         busy;
    logic         done;
    logic         err;
    logic         err_clr = 1'b0;

    logic [W-1:0] bank_q = '0;
    bit           stuck = 1'b0;
    int           done_cnt = 0;

    int n_checks = 0;
    int n_fail   = 0;

    jk_bank_driver #(
        .W         (W),
        .MAX_RETRY (MAXR)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .q_fb      (bank_q),
        .J         (J),
        .K         (K),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference helpers ----------------
    function automatic logic [W-1:0] ref_target(input logic [1:0] op,
                                                input logic [W-1:0] data,
                                                input logic [W-1:0] q);
        logic [W-1:0] r;
        case (op)
            C_LOAD:  r = data;
            C_INC:   r = W'((int'(q) + 1) % (1 << W));
            C_CLR:   r = '0;
            default: r = ~q;
        endcase
        return r;
    endfunction

    // Returns {J, K}
    function automatic logic [2*W-1:0] ref_excite(input logic [W-1:0] q,
                                                  input logic [W-1:0] t);
        logic [W-1:0] j;
        logic [W-1:0] k;
        for (int b = 0; b < W; b++) begin
            if (q[b] == t[b])  begin j[b] = 1'b0; k[b] = 1'b0; end
            else if (t[b])     begin j[b] = 1'b1; k[b] = 1'b0; end
            else               begin j[b] = 1'b0; k[b] = 1'b1; end
        end
        return {j, k};
    endfunction

    // JK flip-flop truth table applied bitwise
    function automatic logic [W-1:0] ref_apply(input logic [W-1:0] q,
                                               input logic [W-1:0] j,
                                               input logic [W-1:0] k);
        logic [W-1:0] n;
        for (int b = 0; b < W; b++) begin
            case ({j[b], k[b]})
                2'b00:   n[b] = q[b];
                2'b10:   n[b] = 1'b1;
                2'b01:   n[b] = 1'b0;
                default: n[b] = ~q[b];
            endcase
        end
        return n;
    endfunction

    // ---------------- behavioural JK bank ----------------
    always @(posedge CLK) begin
        if (!stuck) bank_q <= ref_apply(bank_q, J, K);
    end

    always @(posedge CLK) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // J and K must never be high on the same bit.
    always @(negedge CLK) begin
        if (!RST) check_eq("jk_excl", 32'(J & K), 32'd0);
    end

    // Issue one command at a negedge in IDLE and follow it to DONE or ERR.
    // Returns at a negedge: in IDLE after DONE, or in ERR.
    task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] data,
                           input bit keep_valid, output bit got_err);
        logic [W-1:0]     q;
        logic [W-1:0]     tgt;
        logic [2*W-1:0]   jk;
        int               attempt;
        int               d0;
        bit               fin;
        check_eq("idle_ready", 32'(cmd_ready), 32'd1);
        q   = bank_q;
        tgt = ref_target(op, data, q);
        d0  = done_cnt;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(negedge CLK);
        if (keep_valid) begin
            cmd_op   = 2'($urandom);
            cmd_data = ~data;
        end else begin
            cmd_valid = 1'b0;
        end
        attempt = 0;
        fin     = 1'b0;
        got_err = 1'b0;
        while (!fin) begin
            jk = ref_excite(q, tgt);
            check_eq("drive_J", 32'(J), 32'(jk[2*W-1:W]));
            check_eq("drive_K", 32'(K), 32'(jk[W-1:0]));
            check_eq("drive_busy", 32'(busy), 32'd1);
            check_eq("drive_ready", 32'(cmd_ready), 32'd0);
            check_eq("drive_done", 32'(done), 32'd0);
            @(negedge CLK);
            check_eq("check_JK", 32'({J, K}), 32'd0);
            check_eq("check_busy", 32'(busy), 32'd1);
            check_eq("check_done", 32'(done), 32'd0);
            if (!stuck) q = ref_apply(q, jk[2*W-1:W], jk[W-1:0]);
            check_eq("bank_q", 32'(bank_q), 32'(q));
            @(negedge CLK);
            if (q == tgt) begin
                check_eq("done_pulse", 32'(done), 32'd1);
                check_eq("done_JK", 32'({J, K}), 32'd0);
                check_eq("done_err", 32'(err), 32'd0);
                @(negedge CLK);
                check_eq("post_done", 32'(done), 32'd0);
                check_eq("post_ready", 32'(cmd_ready), 32'd1);
                check_eq("post_busy", 32'(busy), 32'd0);
                check_eq("done_count", 32'(done_cnt - d0), 32'd1);
                check_eq("final_q", 32'(bank_q), 32'(tgt));
                fin = 1'b1;
            end else if (attempt < MAXR) begin
                attempt++;
            end else begin
                check_eq("err_flag", 32'(err), 32'd1);
                check_eq("err_ready", 32'(cmd_ready), 32'd0);
                check_eq("err_busy", 32'(busy), 32'd0);
                check_eq("err_JK", 32'({J, K}), 32'd0);
                check_eq("err_nodone", 32'(done_cnt - d0), 32'd0);
                got_err = 1'b1;
                fin     = 1'b1;
            end
        end
        $display("cmd op=%0d data=%h tgt=%h drives=%0d err=%0d q=%h",
                 op, data, tgt, attempt + 1, got_err, bank_q);
    endtask

    // Called at a negedge while in ERR.
    task automatic clear_err();
        @(negedge CLK);
        check_eq("err_sticky", 32'(err), 32'd1);
        check_eq("err_sticky_ready", 32'(cmd_ready), 32'd0);
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        check_eq("errclr_err", 32'(err), 32'd0);
        check_eq("errclr_ready", 32'(cmd_ready), 32'd1);
        check_eq("errclr_busy", 32'(busy), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit           e;
        logic [W-1:0] q;
        logic [2*W-1:0] jk;
        int           d0;

        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_J", 32'(J), 32'd0);
        check_eq("rst_K", 32'(K), 32'd0);
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // 1: LOAD 1010 from 0000
        run_cmd(C_LOAD, 4'b1010, 1'b0, e);
        // 2: INC wrap from 1111
        run_cmd(C_LOAD, 4'b1111, 1'b0, e);
        run_cmd(C_INC,  4'b0000, 1'b0, e);
        check_eq("inc_wrap", 32'(bank_q), 32'd0);
        // 3: TOG from 0110, then CLR
        run_cmd(C_LOAD, 4'b0110, 1'b0, e);
        run_cmd(C_TOG,  4'b0000, 1'b0, e);
        check_eq("tog_q", 32'(bank_q), 32'b1001);
        run_cmd(C_CLR,  4'b1111, 1'b0, e);
        check_eq("clr_q", 32'(bank_q), 32'd0);
        // 4: stuck bank -> three drives then ERR
        stuck = 1'b1;
        run_cmd(C_LOAD, 4'b0101, 1'b0, e);
        check_eq("stuck_err", 32'(e), 32'd1);
        stuck = 1'b0;
        clear_err();
        // err_clr outside ERR has no effect
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        check_eq("errclr_idle_ready", 32'(cmd_ready), 32'd1);
        check_eq("errclr_idle_busy", 32'(busy), 32'd0);
        // 5: asynchronous reset during DRIVE
        q  = bank_q;
        jk = ref_excite(q, ~q);
        d0 = done_cnt;
        cmd_valid = 1'b1;
        cmd_op    = C_LOAD;
        cmd_data  = ~q;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        check_eq("pre_rst_J", 32'(J), 32'(jk[2*W-1:W]));
        check_eq("pre_rst_K", 32'(K), 32'(jk[W-1:0]));
        #1;
        RST = 1'b1;
        #1;
        check_eq("async_rst_JK", 32'({J, K}), 32'd0);
        check_eq("async_rst_busy", 32'(busy), 32'd0);
        check_eq("async_rst_ready", 32'(cmd_ready), 32'd1);
        @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        check_eq("rst_no_done", 32'(done_cnt - d0), 32'd0);
        check_eq("rst_bank_kept", 32'(bank_q), 32'(q));
        check_eq("rst_idle_ready", 32'(cmd_ready), 32'd1);
        $display("reset during DRIVE: bank q=%h", bank_q);
        // 6: cmd_valid held while busy with changing data
        run_cmd(C_LOAD, 4'b1100, 1'b1, e);
        run_cmd(C_INC,  4'b0000, 1'b0, e);
        check_eq("hold_second_q", 32'(bank_q), 32'b1101);

        // Randomized commands, occasionally with a stuck bank
        for (int n = 0; n < 40; n++) begin
            stuck = ($urandom_range(7, 0) == 0);
            run_cmd(2'($urandom), 4'($urandom), 1'b0, e);
            stuck = 1'b0;
            if (e) clear_err();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_jk_bank_driver
